// File: rtl/uart_rx_param_pkg.sv
// Shared types and helpers for the parametrised oversampling UART receiver.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 majority sampling in rx_bit_sampler).

package uart_rx_pkg;

  // Receiver frame-tracking states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Parity configuration codes
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Widest payload supported; narrower payloads are zero-extended before parity
  localparam int MAX_DATA_BITS = 9;

  // XOR-reduction parity of a payload (zero-extension does not change the result)
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/uart_rx_param_sampler.sv
// Bit sampler for uart_rx_param: 2-flop synchroniser, oversample tick counter
// and mid-bit sample strobe.
// Optional build macro: UART_RX_MAJORITY_EN -- when defined, each sample is the
// 2-of-3 majority of rx_s around the nominal tick and the strobe arrives one
// tick later; when undefined, a single sample is taken at the nominal tick.

module rx_bit_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic bounderClock,
  input  logic reset,
  input  logic rxbit,
  input  logic start,
  input  logic run,
  output logic rx_s,
  output logic sample_strobe,
  output logic sample_value
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);

  logic          sync1;
  logic          sync2;
  logic [TW-1:0] tick;

  // Two-flop synchroniser; idles high so reset never looks like a start edge
  always_ff @(posedge bounderClock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxbit;
      sync2 <= sync1;
    end
  end

  assign rx_s = sync2;

  // Tick counter: the start-detect cycle counts as tick 0, so sampling at
  // TICK_MID lands OVERSAMPLE/2-1 cycles after start detection, every bit
  always_ff @(posedge bounderClock or posedge reset) begin
    if (reset) begin
      tick <= '0;
    end else if (start) begin
      tick <= TW'(1);
    end else if (run) begin
      tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
    end else begin
      tick <= '0;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] TICK_DEC = TW'(OVERSAMPLE / 2);

  logic [1:0] hist;

  // History of the two previous rx_s values feeding the majority vote
  always_ff @(posedge bounderClock or posedge reset) begin
    if (reset) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample_strobe = run && (tick == TICK_DEC);
  assign sample_value  = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign sample_strobe = run && (tick == TICK_MID);
  assign sample_value  = rx_s;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with parity, 1/2 stop bits,
// ready/ack handshake and frame/parity/overrun error reporting.
// Optional build macro: UART_RX_MAJORITY_EN (majority sampling, see rx_bit_sampler).

module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 bounderClock,
  input  logic                 reset,
  input  logic                 rxbit,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] dataout,
  output logic                 OUT_STATUS_READY,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t state;
  rx_state_t state_next;

  logic rx_s;
  logic strobe;
  logic sample;
  logic start_det;
  logic run;

  logic [DATA_BITS-1:0] shift_reg;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 stop_err_r;
  logic                 par_err_r;
  logic                 ready;

  logic load;
  logic shift_en;
  logic par_capture;
  logic stop_capture;
  logic frame_bad;
  logic par_sum;
  logic parity_bad;

  assign start_det = (state == IDLE) && !rx_s;
  assign run       = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);

  rx_bit_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .bounderClock (bounderClock),
    .reset        (reset),
    .rxbit        (rxbit),
    .start        (start_det),
    .run          (run),
    .rx_s         (rx_s),
    .sample_strobe(strobe),
    .sample_value (sample)
  );

  // A stop error from either stop sample marks the whole frame
  assign frame_bad = stop_err_r | !sample;

  // Sum of payload and received parity bit: 0 is correct for even, 1 for odd
  assign par_sum    = calc_parity(MAX_DATA_BITS'(shift_reg)) ^ sample;
  assign parity_bad = (PARITY_MODE == PARITY_ODD) ? !par_sum : par_sum;

  // State register
  always_ff @(posedge bounderClock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-sample control strobes
  always_comb begin
    state_next   = state;
    load         = 1'b0;
    shift_en     = 1'b0;
    par_capture  = 1'b0;
    stop_capture = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        if (strobe) state_next = sample ? IDLE : DATA;
      end
      DATA: begin
        if (strobe) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_next = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (strobe) begin
          par_capture = 1'b1;
          state_next  = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          if ((STOP_BITS == 2) && !stop_cnt) begin
            stop_capture = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = frame_bad ? WAIT_HIGH : IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: payload shift register, bit count and per-frame error capture
  always_ff @(posedge bounderClock or posedge reset) begin
    if (reset) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      stop_err_r <= 1'b0;
      par_err_r  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bit_cnt    <= '0;
        stop_cnt   <= 1'b0;
        stop_err_r <= 1'b0;
        par_err_r  <= 1'b0;
      end
      if (shift_en) begin
        shift_reg <= {sample, shift_reg[DATA_BITS-1:1]};
        bit_cnt   <= bit_cnt + BW'(1);
      end
      if (par_capture) begin
        par_err_r <= parity_bad;
      end
      if (stop_capture) begin
        stop_cnt   <= 1'b1;
        stop_err_r <= !sample;
      end
    end
  end

  // Output registers and handshake: a load always wins over a same-cycle ack
  always_ff @(posedge bounderClock or posedge reset) begin
    if (reset) begin
      dataout     <= '0;
      ready       <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else if (load) begin
      dataout    <= shift_reg;
      frame_err  <= frame_bad;
      parity_err <= (PARITY_MODE != PARITY_NONE) && par_err_r;
      ready      <= 1'b1;
      if (data_ack) begin
        overrun_err <= 1'b0;
      end else if (ready) begin
        overrun_err <= 1'b1;
      end
    end else if (data_ack && ready) begin
      ready       <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

  assign OUT_STATUS_READY = ready;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed testbench for uart_rx_param: one default 8N1 instance and one
// even-parity instance, table-driven frames plus hand-written timing sequences.

module tb_uart_rx_param;
  import uart_rx_pkg::*;

`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rx_line;
  logic       ack  [2];
  logic [7:0] dout [2];
  logic       rdy  [2];
  logic       ferr [2];
  logic       perr [2];
  logic       oerr [2];

  int n_applied = 0;
  int n_miss    = 0;

  typedef struct {
    int         tgt;
    logic [7:0] payload;
    logic       use_par;
    logic       par_bit;
    logic       stop_level;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  uart_rx_param dut0 (
    .bounderClock    (clk),
    .reset           (reset),
    .rxbit           (rx_line[0]),
    .data_ack        (ack[0]),
    .dataout         (dout[0]),
    .OUT_STATUS_READY(rdy[0]),
    .frame_err       (ferr[0]),
    .parity_err      (perr[0]),
    .overrun_err     (oerr[0])
  );

  uart_rx_param #(
    .PARITY_MODE(PARITY_EVEN)
  ) dut1 (
    .bounderClock    (clk),
    .reset           (reset),
    .rxbit           (rx_line[1]),
    .data_ack        (ack[1]),
    .dataout         (dout[1]),
    .OUT_STATUS_READY(rdy[1]),
    .frame_err       (ferr[1]),
    .parity_err      (perr[1]),
    .overrun_err     (oerr[1])
  );

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_applied++;
    if (got !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_applied++;
    if (got !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_output(input string label, input int tgt, input logic [7:0] exp_data,
                              input logic exp_rdy, input logic exp_ferr, input logic exp_perr,
                              input logic exp_oerr);
    check_byte({label, ".dataout"}, dout[tgt], exp_data);
    check_bit({label, ".ready"}, rdy[tgt], exp_rdy);
    check_bit({label, ".frame_err"}, ferr[tgt], exp_ferr);
    check_bit({label, ".parity_err"}, perr[tgt], exp_perr);
    check_bit({label, ".overrun_err"}, oerr[tgt], exp_oerr);
  endtask

  // Drives one frame LSB first, OS ticks per bit, leaving the line idle high
  task automatic apply_stimulus(input int tgt, input logic [7:0] data, input logic use_par,
                                input logic par_bit, input logic stop_level);
    rx_line[tgt] = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line[tgt] = data[i];
      repeat (OS) @(negedge clk);
    end
    if (use_par) begin
      rx_line[tgt] = par_bit;
      repeat (OS) @(negedge clk);
    end
    rx_line[tgt] = stop_level;
    repeat (OS) @(negedge clk);
    rx_line[tgt] = 1'b1;
  endtask

  task automatic pulse_ack(input int tgt);
    ack[tgt] = 1'b1;
    @(negedge clk);
    ack[tgt] = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    rx_line = 2'b11;
    ack[0]  = 1'b0;
    ack[1]  = 1'b0;

    vecs[0]  = '{0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4]  = '{0, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
    vecs[5]  = '{0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[6]  = '{1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    vecs[7]  = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[8]  = '{1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1, 8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[10] = '{1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check_output("reset", 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Ready must rise exactly one cycle after the last stop sample
    fork
      apply_stimulus(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        repeat (153 + LAT) @(negedge clk);
        check_bit("timing.before_load", rdy[0], 1'b0);
        @(negedge clk);
        check_bit("timing.after_load", rdy[0], 1'b1);
      end
    join
    repeat (8) @(negedge clk);
    check_output("a5", 0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_ack(0);
    check_bit("a5.ack_clears_ready", rdy[0], 1'b0);

    // Short low glitch is rejected as a false start
    rx_line[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (30) @(negedge clk);
    check_bit("glitch.ready", rdy[0], 1'b0);
    check_byte("glitch.state", 8'(dut0.state), 8'(IDLE));
    apply_stimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check_output("glitch.next", 0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_ack(0);

    // Table of frames across both instances, each acknowledged afterwards
    for (int v = 0; v < 11; v++) begin
      apply_stimulus(vecs[v].tgt, vecs[v].payload, vecs[v].use_par, vecs[v].par_bit,
                     vecs[v].stop_level);
      repeat (8) @(negedge clk);
      check_output($sformatf("vec%0d", v), vecs[v].tgt, vecs[v].exp_data, 1'b1,
                   vecs[v].exp_ferr, vecs[v].exp_perr, 1'b0);
      pulse_ack(vecs[v].tgt);
      check_bit($sformatf("vec%0d.ack", v), rdy[vecs[v].tgt], 1'b0);
    end

    // Break condition: stop low and line held low keeps the FSM in WAIT_HIGH
    apply_stimulus(0, 8'h96, 1'b0, 1'b0, 1'b0);
    rx_line[0] = 1'b0;
    repeat (40) @(negedge clk);
    check_bit("break.frame_err", ferr[0], 1'b1);
    check_bit("break.ready", rdy[0], 1'b1);
    check_byte("break.dataout", dout[0], 8'h96);
    check_byte("break.state", 8'(dut0.state), 8'(WAIT_HIGH));
    rx_line[0] = 1'b1;
    repeat (8) @(negedge clk);
    check_byte("break.released", 8'(dut0.state), 8'(IDLE));
    pulse_ack(0);
    apply_stimulus(0, 8'h55, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check_output("break.next", 0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_ack(0);

    // Back-to-back frames without ack overrun, ack clears, ack beats nothing on load
    apply_stimulus(0, 8'h11, 1'b0, 1'b0, 1'b1);
    apply_stimulus(0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check_output("overrun", 0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_ack(0);
    check_bit("overrun.ack_ready", rdy[0], 1'b0);
    check_bit("overrun.ack_clear", oerr[0], 1'b0);
    apply_stimulus(0, 8'h44, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check_output("pre_coincident", 0, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    fork
      apply_stimulus(0, 8'h33, 1'b0, 1'b0, 1'b1);
      begin
        repeat (153 + LAT) @(negedge clk);
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
      end
    join
    repeat (8) @(negedge clk);
    check_output("coincident", 0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the 4th data bit aborts the frame
    fork
      apply_stimulus(0, 8'hF0, 1'b0, 1'b0, 1'b1);
      begin
        repeat (70) @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("midreset", 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        reset = 1'b0;
      end
    join
    repeat (8) @(negedge clk);
    check_bit("midreset.no_load", rdy[0], 1'b0);
    apply_stimulus(0, 8'h0F, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check_output("after_reset", 0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised, oversampling serial receiver. Successor to the fixed 8-bit receiver, driven by the same bounderClock, which here runs at OVERSAMPLE × baud. Adds configurable data width, parity, stop bits, a data-valid/acknowledge handshake, and framing/parity/overrun error reporting. Sits between the board RX pin and the game-control logic.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9), LSB first on the wire
OVERSAMPLE, 16, bounderClock ticks per bit period (even, ≥4)
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
bounderClock  in  1  oversample clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
rxbit  in  1  raw serial line, idle high, asynchronous to bounderClock
data_ack  in  1  consumer has taken dataout; clears ready
dataout  out  DATA_BITS  last received payload
OUT_STATUS_READY  out  1  level: unread payload present in dataout
frame_err  out  1  stop bit sampled low in the last loaded frame
parity_err  out  1  parity mismatch in the last loaded frame; always 0 when PARITY_MODE = 0
overrun_err  out  1  sticky: a frame was loaded while ready was still 1

Behaviour:
- Reset (async, active-high): state = IDLE, counters = 0, dataout = 0, all status outputs = 0, synchroniser flops = 1.
- rxbit passes through a 2-flop synchroniser; rx_s is the synchronised line. All sampling uses rx_s.
- Define T0 as the cycle in IDLE where rx_s is first seen low. Sample k is taken at T0 + OVERSAMPLE/2 − 1 + k·OVERSAMPLE:
  - k = 0: start bit
  - k = 1..DATA_BITS: data bits
  - next sample: parity bit, if enabled
  - next 1 or 2 samples: stop bit(s)
- States: IDLE → START → DATA → PARITY (skipped if PARITY_MODE = 0) → STOP → IDLE. Also WAIT_HIGH.
- START: sample reads 1 → false start. Return to IDLE; nothing is loaded and no flag changes.
- DATA: shift register shifts right, and the new bit enters at MSB (bit DATA_BITS−1). After DATA_BITS samples, bit 0 holds the first received bit.
- PARITY: computes even/odd parity over the payload plus the parity bit.
- STOP: any stop sample reads 0 → frame_err for this frame.
- Load event: occurs on the cycle of the last stop sample. On the next cycle:
  - dataout = payload
  - frame_err and parity_err reflect this frame
  - OUT_STATUS_READY = 1
- After the load:
  - frame_err = 0 → next state is IDLE. Back-to-back frames are accepted; a new start edge may be detected from the cycle after the load.
  - frame_err = 1 → next state is WAIT_HIGH, which waits until rx_s = 1 before returning to IDLE (break condition).
- Errored frames are still loaded and still flagged ready.
- Handshake:
  - data_ack = 1 with no load in the same cycle → OUT_STATUS_READY = 0 and overrun_err = 0 next cycle.
  - Load and data_ack in the same cycle → load wins: ready stays 1, no overrun.
  - Load while ready = 1 and no ack → dataout is overwritten and overrun_err = 1 (sticky until an ack).
- data_ack while ready = 0 is ignored.
- Tick counter width is $clog2(OVERSAMPLE). Bit counter width is $clog2(DATA_BITS+1). The tick counter wraps at OVERSAMPLE−1.
- Reset mid-frame aborts the frame immediately: no load and no flags.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each sample is the 2-of-3 majority of rx_s at sample−1, sample and sample+1 ticks. Sample timing is otherwise unchanged, with the decision registered one tick later. Overall latency to ready is +1 cycle.
- Undefined: single sample at the nominal tick.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  - PARITY_NONE/EVEN/ODD constants
  - helper function computing the parity of a DATA_BITS vector
- Sub-module rx_bit_sampler contains the 2-flop synchroniser, the tick counter, and the sample strobe/value, including the majority option.
- The top level holds the FSM, shift register, output registers and handshake.

Test Plan:
- Defaults, send 0xA5 (8N1): OUT_STATUS_READY rises the cycle after sample T0+7+9·16. dataout = 0xA5, frame_err = 0, parity_err = 0.
- Low glitch on rxbit of 4 ticks in IDLE → false start. No ready, state returns to IDLE, the next valid frame 0x3C is received correctly.
- PARITY_MODE = 1, send 0x07 with parity bit 0 → dataout = 0x07, parity_err = 1. Then send 0x07 with parity bit 1 → parity_err = 0.
- Stop bit forced 0, line held low 40 ticks → frame_err = 1 and the FSM stays in WAIT_HIGH. After the line goes high, frame 0x55 is received with frame_err = 0.
- Two back-to-back frames 0x11, 0x22, no ack → dataout = 0x22, overrun_err = 1. A single-cycle data_ack clears ready and overrun_err. Ack coincident with the load of a third frame 0x33 → ready = 1, overrun_err = 0.
- reset asserted at the 4th data bit of frame 0xF0 → all outputs 0 immediately. The next frame 0x0F after release is received correctly.
